// File: rtl/cp0_exc_ctrl_if.sv
// Pipeline-facing bundle of the CP0 exception controller: mfc0/mtc0 access,
// M-stage exception/interrupt status in, redirect request and EPC out.
interface cp0_exc_ctrl_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] Din;
  logic        WE;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        Req;
  logic [31:0] EPCOut;
  logic [31:0] Dout;

  modport master (
    output A1, A2, Din, WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    input  Req, EPCOut, Dout
  );

  modport slave (
    input  A1, A2, Din, WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    output Req, EPCOut, Dout
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller at the M stage: holds SR, Cause,
// EPC and PRId, raises the handler redirect request and services mfc0/mtc0.
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID = 32'h2023_1109
) (
  input  logic            clk,
  input  logic            reset,
  cp0_exc_ctrl_if.slave   bus
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req_s;
  logic        exc_req_s;
  logic        req_s;
  logic        sr_wr_s;
  logic        epc_wr_s;
  logic        exl_wr_s;
  logic [31:0] victim_pc_s;
  logic [31:0] sr_s;
  logic [31:0] cause_s;
  logic [31:0] dout_s;

  // Request decode; an interrupt wins over a simultaneous exception.
  always_comb begin
    int_req_s   = (|(bus.HWInt & im_q)) & ie_q & ~exl_q;
    exc_req_s   = (bus.ExcCodeIn != 5'd0) & ~exl_q;
    req_s       = int_req_s | exc_req_s;
    sr_wr_s     = bus.WE & (bus.A2 == 5'd12);
    epc_wr_s    = bus.WE & (bus.A2 == 5'd14);
    victim_pc_s = bus.BDIn ? (bus.VPC - 32'd4) : bus.VPC;
  end

  // Next-state for SR/Cause/EPC; taking an exception discards mtc0 and eret.
  always_comb begin
    im_d       = im_q;
    ie_d       = ie_q;
    exl_d      = exl_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    exl_wr_s   = exl_q;
    ip_d       = bus.HWInt;
    if (req_s) begin
      exl_d      = 1'b1;
      exc_code_d = int_req_s ? 5'd0 : bus.ExcCodeIn;
      bd_d       = bus.BDIn;
      epc_d      = {victim_pc_s[31:2], 2'b00};
    end else begin
      // A same-cycle SR write lands first, then eret clears EXL on top of it.
      im_d     = sr_wr_s ? bus.Din[15:10] : im_q;
      ie_d     = sr_wr_s ? bus.Din[0] : ie_q;
      exl_wr_s = sr_wr_s ? bus.Din[1] : exl_q;
      exl_d    = bus.EXLClr ? 1'b0 : exl_wr_s;
      epc_d    = epc_wr_s ? bus.Din : epc_q;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q       <= 6'd0;
      ie_q       <= 1'b0;
      exl_q      <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      ie_q       <= ie_d;
      exl_q      <= exl_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  // mfc0 read mux returns the pre-edge register contents.
  always_comb begin
    sr_s    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    cause_s = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
    case (bus.A1)
      5'd12:   dout_s = sr_s;
      5'd13:   dout_s = cause_s;
      5'd14:   dout_s = epc_q;
      5'd15:   dout_s = PRID;
      default: dout_s = 32'd0;
    endcase
  end

  assign bus.Req    = req_s;
  assign bus.EPCOut = epc_q;
  assign bus.Dout   = dout_s;

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 exception/interrupt controller for the pipelined MIPS core.
- Sits at the M stage.
- Produces the Req flag that redirects the next-PC logic to handler 0x0000_4180, and the EPC value used by eret.
- Holds the SR, Cause, EPC and PRId registers and services mfc0/mtc0.

Parameters:
- PRID, 32'h2023_1109, constant value returned on reads of register 15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- A1  input  5  mfc0 read register number.
- A2  input  5  mtc0 write register number.
- Din  input  32  mtc0 write data.
- WE  input  1  mtc0 write enable.
- VPC  input  32  PC of the M-stage instruction (victim PC).
- BDIn  input  1  M-stage instruction sits in a branch delay slot.
- ExcCodeIn  input  5  M-stage exception code; 0 = no exception.
- HWInt  input  6  external hardware interrupt lines [7:2].
- EXLClr  input  1  eret in M stage; clears SR.EXL.
- Req  output  1  take exception/interrupt this cycle (combinational).
- EPCOut  output  32  current EPC register value.
- Dout  output  32  mfc0 read data (combinational).

Behaviour:
- Registers:
  - SR(12): IM=[15:10], EXL=[1], IE=[0]; all other bits read 0.
  - Cause(13): BD=[31], IP=[15:10], ExcCode=[6:2]; all other bits read 0.
  - EPC(14): full 32 bits.
- Reset (async, immediate on reset high): SR, Cause and EPC = 0, so Req = 0, EPCOut = 0, Dout = 0 for A1 in {12,13,14}. Reset mid-handler drops EXL to 0.
- Request logic (combinational, same cycle):
  - IntReq = (|(HWInt & SR.IM)) & SR.IE & ~SR.EXL.
  - ExcReq = (ExcCodeIn != 0) & ~SR.EXL.
  - Req = IntReq | ExcReq.
  - Interrupt has priority over a simultaneous exception.
- On rising edge with Req=1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= IntReq ? 0 : ExcCodeIn.
  - Cause.BD <= BDIn.
  - EPC <= BDIn ? VPC-4 : VPC, with bits [1:0] forced to 0.
  - A concurrent mtc0 (WE) is discarded; a concurrent EXLClr is ignored.
- Cause.IP <= HWInt on every edge, regardless of Req or EXL.
- On rising edge with Req=0 and WE=1:
  - A2=12: SR <= Din masked to IM/EXL/IE.
  - A2=14: EPC <= Din.
  - Other numbers (including 13 and 15): no effect. Cause and PRId are read-only.
- On rising edge with Req=0 and EXLClr=1: SR.EXL <= 0.
  - If WE with A2=12 in the same cycle, the written value is applied first, then EXL is cleared.
- Dout = register selected by A1: 12 SR, 13 Cause, 14 EPC, 15 PRID, anything else 0.
  - Read returns the pre-edge value; no write-through bypass.
- EPCOut = EPC register (registered value). The pipeline stalls eret behind an in-flight mtc0 EPC.
- Nested events while EXL=1: no Req; EPC and Cause.ExcCode hold their values; IP keeps tracking HWInt.
- Latency: Req has 0-cycle latency; register effects are visible 1 cycle later.

Test Plan:
- Reset, then mtc0 SR=32'h0000_FC01 (A2=12), then HWInt=6'b000100 -> Req=1 in the same cycle. Next cycle: SR.EXL=1, Cause=32'h0000_1000 (IP[12] set, ExcCode 0), EPC=VPC, Req=0.
- ExcCodeIn=5'd4 (AdEL), VPC=32'h0000_3008, BDIn=1 -> Req=1. After the edge: EPC=32'h0000_3004, Cause[31]=1, Cause[6:2]=4.
- Exception and interrupt in the same cycle (ExcCodeIn=10, enabled HWInt) -> ExcCode latched 0; EPC=VPC.
- With EXL=1, ExcCodeIn=12 plus an enabled HWInt -> Req=0; EPC unchanged. Then EXLClr -> EXL=0, and the pending enabled interrupt raises Req the next cycle.
- WE with A2=14, Din=32'h0000_3abc, simultaneous with ExcCodeIn=8 at VPC=32'h0000_3100 -> EPC=32'h0000_3100 (write dropped). mtc0 to 13 leaves Cause unchanged. Read A1=15 -> PRID. Read A1=7 -> 0.
- Assert reset asynchronously mid-handler (EXL=1, EPC nonzero) -> SR, Cause, EPC and EPCOut all become 0 before the next clock edge.
